wb_aperture_decoder: RTL
========================

# wb_aperture_decoder

Parametrised Wishbone slave-side interconnect for the FPGA IP top level. It decodes `NUM_SLAVES` address apertures and gates a per-slave cycle select, registering the selected slave's read data and acknowledge back to the AHB-to-FPGA bridge. Accesses to unmapped addresses are terminated with a default read value. Unresponsive slaves are terminated with the same value after a bounded timeout. Address, write data, byte strobes and WE fan out directly from the bridge to slaves; they do not pass through this block.

## Interface
- `NUM_SLAVES`, 4: number of apertures/slaves (1–16).
- `APERWIDTH`, 17: bridge byte-address width.
- `APERSIZE`, 10: word-address bits per aperture; decode compares `ADR[APERWIDTH-1:APERSIZE+2]`.
- `SLAVE_BASE_ADDRS`, {17'h05000,17'h02000,17'h01000,17'h00000}: packed `NUM_SLAVES*APERWIDTH` byte base addresses; slave i is at slice i.
- `DEFAULT_READ_VALUE`, 32'hBAD_FAB_AC: data returned on miss or timeout.
- `TIMEOUT_CNTR_WIDTH`, 4: timeout counter width.
- `TIMEOUT_CYCLES`, 15: cycles a selected slave may take before forced termination (1 to 2^width−1).
- `WBs_CLK_i`, in, 1: Wishbone clock. Single clock.
- `WBs_RST_i`, in, 1: synchronous, active-high reset.
- `WBs_ADR_i`, in, `APERWIDTH`: byte address.
- `WBs_CYC_i`, in, 1: bus cycle.
- `WBs_STB_i`, in, 1: transfer strobe.
- `WBs_DAT_o`, out, 32: registered read data to bridge.
- `WBs_ACK_o`, out, 1: registered one-cycle acknowledge to bridge.
- `s_CYC_o`, out, `NUM_SLAVES`: one-hot, registered per-slave cycle select.
- `s_DAT_i`, in, `NUM_SLAVES*32`: packed slave read data; slave i occupies `[32i+31:32i]`.
- `s_ACK_i`, in, `NUM_SLAVES`: slave acknowledges.
- `err_irq_o`, out, 1: error pulse (see Configuration).
- `err_addr_o`, out, `APERWIDTH`: last error address.
- `err_cnt_o`, out, 8: error count.

## Operation
- FSM states: IDLE, ACTIVE, RESP.
- IDLE: on `WBs_CYC_i & WBs_STB_i`, decode the address.
  - Hit: latch `sel` and go to ACTIVE.
  - Miss: load `DEFAULT_READ_VALUE` into `WBs_DAT_o`, flag an error, and go to RESP.
- Overlapping apertures: the lowest index wins.
- ACTIVE: `s_CYC_o[sel]`=1 and the counter increments every cycle.
  - `s_ACK_i[sel]`=1: capture `s_DAT_i[sel]` into `WBs_DAT_o`, drop `s_CYC_o`, go to RESP.
  - Otherwise, when `cnt == TIMEOUT_CYCLES-1`: load `DEFAULT_READ_VALUE`, flag an error, go to RESP.
  - Slave ACK in the same cycle as timeout: ACK wins and no error is flagged.
  - `s_ACK_i` bits of unselected slaves are ignored.
- ACTIVE, `WBs_CYC_i` falls (master abort): clear `s_CYC_o`, return to IDLE, no `WBs_ACK_o`, no error.
- RESP: `WBs_ACK_o`=1 for exactly one cycle, then IDLE. The counter clears.
- Reads and writes are handled identically. Write responses carry don't-care data, but a miss or timeout still loads `DEFAULT_READ_VALUE`.
- Reset values:
  - State IDLE; `s_CYC_o`=0; `WBs_ACK_o`=0; `WBs_DAT_o`=0; counter 0.
  - `err_irq_o`=0; `err_addr_o`=0; `err_cnt_o`=0.
- Reset asserted mid-transfer forces these values on the next edge and drops the transfer silently.

## Timing
- Request sampled in cycle N.
- Hit: `s_CYC_o[sel]` high from cycle N+1. With the slave ACKing in cycle M, `WBs_ACK_o` and data are valid in cycle M+1. Minimum `WBs_ACK_o` is cycle N+2.
- Miss: `WBs_ACK_o` in cycle N+1.
- Timeout: `s_CYC_o` high in cycles N+1 … N+`TIMEOUT_CYCLES`; `WBs_ACK_o` in cycle N+`TIMEOUT_CYCLES`+1.
- `s_CYC_o` deasserts in the cycle after the slave ACK, so a slave never sees a second access.
- A back-to-back request is accepted in the cycle after RESP.

## Configuration
- `WB_DECODE_ERR_CAPTURE_EN` defined:
  - Each miss or timeout produces a one-cycle `err_irq_o` pulse, coincident with `WBs_ACK_o`.
  - `err_addr_o` latches the failing `WBs_ADR_i`.
  - `err_cnt_o` increments and saturates at 255.
- Not defined: the three error outputs are tied to 0 and no capture logic is built. Port list is unchanged.

## Structure
- Package `wb_decode_pkg`:
  - FSM state enum.
  - `DEFAULT_READ_VALUE` constant.
  - Data width constant (32).
  - Helper function extracting base slice i from `SLAVE_BASE_ADDRS`.
- Sub-module `wb_timeout_counter`: clear/enable/terminal-count, parametrised by width and terminal value.

## Test plan
- Read at `17'h01004` (slave 1) with slave ACK one cycle after `s_CYC_o[1]` rises, `s_DAT_i` slice 1 = 32'hCAFE0001 → `WBs_ACK_o` one cycle later with 32'hCAFE0001; `s_CYC_o` one-hot 4'b0010 for 2 cycles.
- Read at `17'h03000` (unmapped) → `WBs_ACK_o` in cycle N+1, data 32'hBAD_FAB_AC, `s_CYC_o` stays 0.
- Slave 2 never ACKs, `TIMEOUT_CYCLES`=15 → `s_CYC_o[2]` high 15 cycles, ACK in cycle N+16 with 32'hBAD_FAB_AC. With `WB_DECODE_ERR_CAPTURE_EN`: `err_irq_o` pulse, `err_addr_o`=`17'h02000`, `err_cnt_o`=1.
- Slave ACK exactly in the terminal-count cycle → slave data returned, no `err_irq_o`.
- Master drops `WBs_CYC_i` in ACTIVE → `s_CYC_o` clears next cycle, no `WBs_ACK_o`. Next request proceeds normally.
- `WBs_RST_i` pulsed while ACTIVE → all outputs 0 on the next edge; a subsequent read of slave 0 completes.

Source files
------------

// File: rtl/wb_decode_pkg.sv
// Shared types and constants for the Wishbone aperture decoder.
// Holds the FSM state enum, the bus data width and the base-address slice helper.
package wb_decode_pkg;

    localparam int DATA_W     = 32;
    localparam int MAX_SLAVES = 16;
    localparam int MAX_ADDR_W = 32;

    localparam logic [DATA_W-1:0] DEFAULT_READ_VALUE = 32'hBAD_FAB_AC;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Caller zero-extends the packed base list and truncates the result to its address width.
    function automatic logic [MAX_ADDR_W-1:0] base_slice(
        input logic [MAX_SLAVES*MAX_ADDR_W-1:0] bases,
        input int                               idx,
        input int                               aw
    );
        logic [MAX_SLAVES*MAX_ADDR_W-1:0] shifted;
        shifted = bases >> (idx * aw);
        return shifted[MAX_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Up-counter with synchronous clear, count enable and terminal-count flag.
// Holds at the terminal value so it can never wrap while the owner is still waiting.
module wb_timeout_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 14
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign tc = (cnt_q == WIDTH'(TERMINAL));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !tc) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_aperture_decoder.sv
// Wishbone aperture decoder: per-slave cycle select, registered ack/data, miss and timeout termination.
// Optional error capture (irq pulse, failing address, saturating count) under WB_DECODE_ERR_CAPTURE_EN.
//
// state     | meaning
// ST_IDLE   | waiting for CYC&STB; decodes address, hit -> ACTIVE, miss -> RESP
// ST_ACTIVE | s_CYC_o[sel] driven; waiting for slave ack, timeout or master abort
// ST_RESP   | WBs_ACK_o high for this single cycle
module wb_aperture_decoder #(
    parameter int                                NUM_SLAVES         = 4,
    parameter int                                APERWIDTH          = 17,
    parameter int                                APERSIZE           = 10,
    parameter logic [NUM_SLAVES*APERWIDTH-1:0]   SLAVE_BASE_ADDRS   = {17'h05000, 17'h02000, 17'h01000, 17'h00000},
    parameter logic [wb_decode_pkg::DATA_W-1:0]  DEFAULT_READ_VALUE = wb_decode_pkg::DEFAULT_READ_VALUE,
    parameter int                                TIMEOUT_CNTR_WIDTH = 4,
    parameter int                                TIMEOUT_CYCLES     = 15
) (
    input  logic                                     WBs_CLK_i,
    input  logic                                     WBs_RST_i,
    input  logic [APERWIDTH-1:0]                     WBs_ADR_i,
    input  logic                                     WBs_CYC_i,
    input  logic                                     WBs_STB_i,
    output logic [wb_decode_pkg::DATA_W-1:0]         WBs_DAT_o,
    output logic                                     WBs_ACK_o,
    output logic [NUM_SLAVES-1:0]                    s_CYC_o,
    input  logic [NUM_SLAVES*wb_decode_pkg::DATA_W-1:0] s_DAT_i,
    input  logic [NUM_SLAVES-1:0]                    s_ACK_i,
    output logic                                     err_irq_o,
    output logic [APERWIDTH-1:0]                     err_addr_o,
    output logic [7:0]                               err_cnt_o
);

    import wb_decode_pkg::*;

    localparam int SEL_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int DEC_LSB = APERSIZE + 2;
    localparam logic [MAX_SLAVES*MAX_ADDR_W-1:0] BASES_EXT = (MAX_SLAVES*MAX_ADDR_W)'(SLAVE_BASE_ADDRS);

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   s_cyc_q, s_cyc_d;
    logic                    ack_q, ack_d;
    logic [DATA_W-1:0]       dat_q, dat_d;

    logic [NUM_SLAVES-1:0]   match;
    logic                    hit;
    logic [SEL_W-1:0]        hit_idx;
    logic [DATA_W-1:0]       s_dat_arr [NUM_SLAVES];
    logic                    req;
    logic                    slave_ack;
    logic                    tmo_tc;
    logic                    cnt_en;
    logic                    err_event;

    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
        localparam logic [APERWIDTH-1:0] BASE = APERWIDTH'(base_slice(BASES_EXT, g, APERWIDTH));
        assign match[g]     = (WBs_ADR_i[APERWIDTH-1:DEC_LSB] == BASE[APERWIDTH-1:DEC_LSB]);
        assign s_dat_arr[g] = s_DAT_i[g*DATA_W +: DATA_W];
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign req       = WBs_CYC_i & WBs_STB_i;
    assign slave_ack = |(s_ACK_i & s_cyc_q);
    assign cnt_en    = (state_q == ST_ACTIVE);

    wb_timeout_counter #(
        .WIDTH    (TIMEOUT_CNTR_WIDTH),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_tmo (
        .clk (WBs_CLK_i),
        .rst (WBs_RST_i),
        .clr (!cnt_en),
        .en  (cnt_en),
        .tc  (tmo_tc)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        s_cyc_d   = s_cyc_q;
        ack_d     = 1'b0;
        dat_d     = dat_q;
        err_event = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        s_cyc_d = NUM_SLAVES'(1) << hit_idx;
                        state_d = ST_ACTIVE;
                    end else begin
                        dat_d     = DEFAULT_READ_VALUE;
                        ack_d     = 1'b1;
                        err_event = 1'b1;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_ACTIVE: begin
                // Abort beats ack: the master has already walked away from this cycle.
                if (!WBs_CYC_i) begin
                    s_cyc_d = '0;
                    state_d = ST_IDLE;
                end else if (slave_ack) begin
                    dat_d   = s_dat_arr[sel_q];
                    s_cyc_d = '0;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (tmo_tc) begin
                    dat_d     = DEFAULT_READ_VALUE;
                    s_cyc_d   = '0;
                    ack_d     = 1'b1;
                    err_event = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                s_cyc_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            s_cyc_q <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            s_cyc_q <= s_cyc_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

    assign WBs_DAT_o = dat_q;
    assign WBs_ACK_o = ack_q;
    assign s_CYC_o   = s_cyc_q;

`ifdef WB_DECODE_ERR_CAPTURE_EN
    logic                 err_irq_q, err_irq_d;
    logic [APERWIDTH-1:0] err_addr_q, err_addr_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    // Registered alongside ack_q so the irq pulse lands in the same cycle as WBs_ACK_o.
    always_comb begin
        err_irq_d  = err_event;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (err_event) begin
            err_addr_d = WBs_ADR_i;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_irq_q  <= err_irq_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_irq_o  = err_irq_q;
    assign err_addr_o = err_addr_q;
    assign err_cnt_o  = err_cnt_q;
`else
    logic unused_sink;
    assign unused_sink = ^{err_event, WBs_ADR_i[DEC_LSB-1:0]};

    assign err_irq_o  = 1'b0;
    assign err_addr_o = '0;
    assign err_cnt_o  = '0;
`endif

endmodule
